// File: rtl/pipeline_pkg.sv
// Shared decode definitions: opcodes, field positions, widths and the ID/EX control bundle.
package pipeline_pkg;
    localparam int PC_W   = 7;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int RA_W   = 5;

    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int FN_HI = 5,  FN_LO = 0;
    localparam int IMM_W = 16;

    typedef enum logic [5:0] {
        OP_R    = 6'b000000,
        OP_J    = 6'b000010,
        OP_BEQ  = 6'b000100,
        OP_BNE  = 6'b000101,
        OP_ADDI = 6'b001000,
        OP_LW   = 6'b100011,
        OP_SW   = 6'b101011
    } opcode_e;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [5:0]      op;
        logic [5:0]      funct;
        logic [RA_W-1:0] rd;
    } id_ctl_t;
endpackage

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write register file, r0 hard-wired to zero.
// DECODE_BYPASS_EN: reads see a same-cycle writeback (write-first).
module reg_file
    import pipeline_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   ra_a,
    input  logic [RA_W-1:0]   ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd
);
    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && wa != '0) regs_d[wa] = wd;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) regs_q <= '0;
        else      regs_q <= regs_d;
    end

`ifdef DECODE_BYPASS_EN
    // Next-state view already merges the pending write.
    assign rd_a = regs_d[ra_a];
    assign rd_b = regs_d[ra_b];
`else
    assign rd_a = regs_q[ra_a];
    assign rd_b = regs_q[ra_b];
`endif
endmodule

// File: rtl/decode_stage.sv
// ID stage: field decode, regfile, load-use stall, BEQ/BNE/J redirect, ID/EX register.
// Optional DECODE_BYPASS_EN selects a write-first register file.
module decode_stage
    import pipeline_pkg::*;
#(
    parameter int PC_W   = 7,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_load,
    input  logic [4:0]        ex_rd,
    output logic              fetch_enbl,
    output logic              dec,
    output logic [PC_W-1:0]   pc_target,
    output logic              id_valid,
    output logic [5:0]        id_op,
    output logic [5:0]        id_funct,
    output logic [DATA_W-1:0] id_rs_val,
    output logic [DATA_W-1:0] id_rt_val,
    output logic [DATA_W-1:0] id_imm,
    output logic [4:0]        id_rd,
    output logic              id_illegal
);
    logic [5:0]        op;
    logic [RA_W-1:0]   rs, rt, rd;
    logic [IMM_W-1:0]  imm16;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    logic              legal, uses_rt, stall, taken, redirect;
    logic [RA_W-1:0]   dest;

    id_ctl_t           ctl_q, ctl_d;
    logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, imm_q, imm_d;
    logic              squash_q, squash_d;

    assign op      = instr[OP_HI:OP_LO];
    assign rs      = instr[RS_HI:RS_LO];
    assign rt      = instr[RT_HI:RT_LO];
    assign rd      = instr[RD_HI:RD_LO];
    assign imm16   = instr[IMM_W-1:0];
    assign imm_ext = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};

    reg_file #(.NREG(NREG), .DATA_W(DATA_W)) u_rf (
        .clk (clk),     .rst (rst),
        .ra_a(rs),      .ra_b(rt),
        .rd_a(rs_val),  .rd_b(rt_val),
        .we  (wb_en),   .wa  (wb_addr), .wd(wb_data)
    );

    always_comb begin
        legal   = 1'b1;
        uses_rt = 1'b0;
        dest    = '0;
        case (op)
            OP_R:           begin dest = rd; uses_rt = 1'b1; end
            OP_ADDI, OP_LW: dest = rt;
            OP_BEQ, OP_BNE,
            OP_SW:          uses_rt = 1'b1;
            OP_J:           ;
            default:        legal = 1'b0;
        endcase
    end

    // A squashed slot is a bubble, so it can neither stall nor redirect.
    assign stall = !squash_q && ex_load && ex_rd != '0 &&
                   (ex_rd == rs || (ex_rd == rt && uses_rt));
    assign taken = (op == OP_BEQ && rs_val == rt_val) ||
                   (op == OP_BNE && rs_val != rt_val) || op == OP_J;
    assign redirect   = rst && !squash_q && !stall && taken;
    assign dec        = redirect;
    assign fetch_enbl = !rst || !stall;
    assign pc_target  = (op == OP_J) ? instr[PC_W-1:0] : pc_in + imm16[PC_W-1:0];

    always_comb begin
        squash_d = redirect;
        ctl_d    = '0;
        rs_val_d = '0;
        rt_val_d = '0;
        imm_d    = '0;
        if (!squash_q && !stall) begin
            if (!legal) begin
                ctl_d.illegal = 1'b1;
            end else begin
                ctl_d.valid = 1'b1;
                ctl_d.op    = op;
                ctl_d.funct = instr[FN_HI:FN_LO];
                ctl_d.rd    = dest;
                rs_val_d    = rs_val;
                rt_val_d    = rt_val;
                imm_d       = imm_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            squash_q <= 1'b1;
            ctl_q    <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
        end else begin
            squash_q <= squash_d;
            ctl_q    <= ctl_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
        end
    end

    assign id_valid   = ctl_q.valid;
    assign id_illegal = ctl_q.illegal;
    assign id_op      = ctl_q.op;
    assign id_funct   = ctl_q.funct;
    assign id_rd      = ctl_q.rd;
    assign id_rs_val  = rs_val_q;
    assign id_rt_val  = rt_val_q;
    assign id_imm     = imm_q;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then random traffic vs. a behavioural model.
module tb_decode_stage;
    localparam logic [5:0] R = 6'd0, J = 6'd2, BEQ = 6'd4, BNE = 6'd5,
                           ADDI = 6'd8, LW = 6'h23, SW = 6'h2B;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] instr = '0, wb_data = '0;
    logic [6:0]  pc_in = '0;
    logic        wb_en = 1'b0, ex_load = 1'b0;
    logic [4:0]  wb_addr = '0, ex_rd = '0;
    logic        fetch_enbl, dec, id_valid, id_illegal;
    logic [6:0]  pc_target;
    logic [5:0]  id_op, id_funct;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic [4:0]  id_rd;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_load(ex_load), .ex_rd(ex_rd),
        .fetch_enbl(fetch_enbl), .dec(dec), .pc_target(pc_target),
        .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rd(id_rd), .id_illegal(id_illegal)
    );

    typedef struct {
        bit          illegal;
        logic [5:0]  op, funct;
        logic [31:0] rs_v, rt_v, imm;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs[32];
    bit          squash = 1'b1;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return regs[a];
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {R, s, t, d, 5'd0, 6'h20};
    endfunction

    // One ID cycle: apply inputs, check redirect/enable, predict the ID/EX bundle, advance the model.
    task automatic step(input logic r, input logic [31:0] ins, input logic [6:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic exl, input logic [4:0] exr);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] a, b;
        bit          stall, taken, legal, urt;
        int          tgt;
        exp_t        e;
        @(negedge clk);
        rst = r; instr = ins; pc_in = pc; wb_en = we; wb_addr = wa; wb_data = wd;
        ex_load = exl; ex_rd = exr;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        a = rdreg(rs); b = rdreg(rt);
        legal = op inside {R, J, BEQ, BNE, ADDI, LW, SW};
        urt   = op inside {R, BEQ, BNE, SW};
        stall = r && !squash && exl && exr != 0 && (exr == rs || (exr == rt && urt));
        taken = r && !squash && !stall &&
                ((op == BEQ && a == b) || (op == BNE && a != b) || op == J);
        tgt = (op == J) ? int'(ins[6:0]) : ((int'(pc) + int'($signed(ins[15:0]))) & 127);
        #1;
        chk("dec", dec, taken);
        chk("fetch_enbl", fetch_enbl, !stall);
        if (taken) chk("pc_target", pc_target, tgt);
        if (r && !squash && !stall) begin
            e.illegal = !legal;
            e.op = op; e.funct = ins[5:0]; e.rs_v = a; e.rt_v = b;
            e.imm = int'($signed(ins[15:0]));
            e.rd = (op == R) ? ins[15:11] : (op inside {ADDI, LW}) ? rt : 5'd0;
            q.push_back(e);
        end
        if (!r) begin
            squash = 1'b1;
            foreach (regs[i]) regs[i] = '0;
        end else begin
            squash = taken;
            if (we && wa != 0) regs[wa] = wd;
        end
    endtask

    // Monitor: whenever the DUT presents a bundle, pop the oldest prediction and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (id_valid === 1'b1 || id_illegal === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_output: got valid=%0b illegal=%0b expected none at %0t",
                         id_valid, id_illegal, $time);
            end else begin
                e = q.pop_front();
                chk("id_illegal", id_illegal, e.illegal);
                chk("id_valid", id_valid, !e.illegal);
                if (!e.illegal) begin
                    chk("id_op", id_op, e.op);
                    chk("id_funct", id_funct, e.funct);
                    chk("id_rs_val", id_rs_val, e.rs_v);
                    chk("id_rt_val", id_rt_val, e.rt_v);
                    chk("id_imm", id_imm, e.imm);
                    chk("id_rd", id_rd, e.rd);
                end
            end
        end
    end

    initial begin
        foreach (regs[i]) regs[i] = '0;
        repeat (3) step(0, NOP, 7'd0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_illegal", id_illegal, 0);
        step(1, rtype(1, 2, 3), 7'd0, 0, 0, 0, 0, 0);         // squashed slot after reset
        @(posedge clk); #1;
        chk("post_rst_bubble", id_valid, 0);
        step(1, {ADDI, 5'd0, 5'd1, 16'd5}, 7'd1, 0, 0, 0, 0, 0);
        step(1, NOP, 7'd2, 1, 5'd1, 32'd5, 0, 0);
        step(1, NOP, 7'd3, 0, 0, 0, 0, 0);
        step(1, rtype(1, 0, 3), 7'd4, 0, 0, 0, 0, 0);
        step(1, rtype(2, 4, 3), 7'd5, 0, 0, 0, 1, 5'd2);      // load-use stall
        step(1, rtype(2, 4, 3), 7'd5, 0, 0, 0, 0, 0);
        step(1, {BEQ, 5'd0, 5'd0, 16'd3}, 7'd10, 0, 0, 0, 0, 0);
        step(1, rtype(1, 1, 7), 7'd11, 0, 0, 0, 0, 0);
        step(1, {J, 26'h7F}, 7'd20, 0, 0, 0, 0, 0);
        step(1, NOP, 7'd21, 0, 0, 0, 0, 0);
        step(1, {BNE, 5'd1, 5'd0, 16'd5}, 7'd126, 0, 0, 0, 0, 0);
        step(1, NOP, 7'd127, 0, 0, 0, 0, 0);
        step(1, NOP, 7'd3, 1, 5'd5, 32'h11, 0, 0);
        step(1, NOP, 7'd4, 0, 0, 0, 0, 0);
        step(1, rtype(5, 0, 6), 7'd5, 1, 5'd5, 32'hA5, 0, 0); // same-cycle write/read
        step(1, rtype(5, 0, 6), 7'd6, 0, 0, 0, 0, 0);
        step(1, {6'h3F, 26'h1234}, 7'd7, 0, 0, 0, 0, 0);     // illegal opcode

        for (int k = 0; k < 1500; k++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            int          s;
            s = $urandom_range(0, 9);
            case (s)
                0: op = R;    1: op = J;   2: op = BEQ; 3: op = BNE;
                4: op = ADDI; 5: op = LW;  6: op = SW;  7: op = R;
                default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom), 6'($urandom)};
            step(($urandom_range(0, 49) != 0), ins, 7'($urandom),
                 1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
        end

        repeat (3) step(1, NOP, 7'd0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
